reorder_buffer: RTL and testbench

Eight-entry circular reorder buffer for the Tomasulo core. Sits beside the issue queue: the issue queue allocates an entry per dispatched instruction and receives the destination tag. The CDB writes results back by tag. Entries retire strictly in program order into the register file, and the block exports a per-tag "value calculated" vector that the reservation stations consume.

---
 rtl/reorder_buffer.sv | 148 ++++++++++++++
 tb/tb_reorder_buffer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - eight-entry circular reorder buffer with in-order retire
//
// Purpose: holds dispatched instructions between issue and retirement. The issue
// queue allocates one entry per cycle at the tail, the CDB writes results back by
// tag (any number of tags per cycle), and the entry at the head retires into the
// register file once its result is present.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   flush                 synchronous squash of every entry
//   alloc, alloc_rd       allocate one entry at the tail with this destination
//   rob_full              no free entry (alloc ignored while high)
//   rd_rob_tag            tag the next allocation receives (tail pointer)
//   cdb_enable, cdb_data  per-tag result broadcast, slice i = [32i+31:32i]
//   robs_calculated       per-tag busy & result written
//   srcN_tag/srcN_rob_data combinational operand lookup by tag
//   regfile_load/rd/data/tag  commit write port toward the register file

module reorder_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic                          alloc,
    input  logic [4:0]                    alloc_rd,
    output logic                          rob_full,
    output logic [$clog2(DEPTH)-1:0]      rd_rob_tag,
    input  logic [DEPTH-1:0]              cdb_enable,
    input  logic [DEPTH*32-1:0]           cdb_data,
    output logic [DEPTH-1:0]              robs_calculated,
    input  logic [$clog2(DEPTH)-1:0]      src1_tag,
    input  logic [$clog2(DEPTH)-1:0]      src2_tag,
    output logic [31:0]                   src1_rob_data,
    output logic [31:0]                   src2_rob_data,
    output logic                          regfile_load,
    output logic [4:0]                    regfile_rd,
    output logic [31:0]                   regfile_data,
    output logic [$clog2(DEPTH)-1:0]      regfile_tag
);

    localparam int TAG_W = $clog2(DEPTH);
    localparam int CNT_W = TAG_W + 1;

    logic [DEPTH-1:0] busy_q,  busy_d;
    logic [DEPTH-1:0] ready_q, ready_d;
    logic [4:0]       rd_q    [DEPTH];
    logic [4:0]       rd_d    [DEPTH];
    logic [31:0]      data_q  [DEPTH];
    logic [31:0]      data_d  [DEPTH];
    logic [TAG_W-1:0] head_q,  head_d;
    logic [TAG_W-1:0] tail_q,  tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic commit;
    logic do_alloc;

    function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
        return (p == TAG_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Fullness is judged on the registered count, so an alloc arriving while
    // full is refused even if the head retires on the same edge.
    assign rob_full = (count_q == CNT_W'(DEPTH));
    assign do_alloc = alloc & ~rob_full;

    // Commit looks only at registered state: a CDB write landing on the head
    // entry becomes visible one cycle later, and commit follows from there.
    assign commit = busy_q[head_q] & ready_q[head_q];

    assign rd_rob_tag      = tail_q;
    assign robs_calculated = busy_q & ready_q;
    assign src1_rob_data   = data_q[src1_tag];
    assign src2_rob_data   = data_q[src2_tag];
    assign regfile_rd      = rd_q[head_q];
    assign regfile_data    = data_q[head_q];
    assign regfile_tag     = head_q;
    // x0 destinations still retire, they just never write the register file.
    assign regfile_load    = commit & (rd_q[head_q] != 5'd0);

    always_comb begin
        busy_d  = busy_q;
        ready_d = ready_q;
        rd_d    = rd_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (flush) begin
            busy_d  = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Writeback only lands on entries that were busy before this edge.
            for (int i = 0; i < DEPTH; i++) begin
                if (cdb_enable[i] && busy_q[i]) begin
                    data_d[i]  = cdb_data[32*i +: 32];
                    ready_d[i] = 1'b1;
                end
            end

            if (commit) begin
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = ptr_inc(head_q);
            end

            // When not full the tail never aliases a busy head, so this cannot
            // collide with the commit clear above.
            if (do_alloc) begin
                busy_d[tail_q]  = 1'b1;
                ready_d[tail_q] = 1'b0;
                rd_d[tail_q]    = alloc_rd;
                tail_d          = ptr_inc(tail_q);
            end

            count_d = count_q + CNT_W'(do_alloc) - CNT_W'(commit);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q  <= '0;
            ready_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            ready_q <= ready_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= rd_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - scoreboard bench for reorder_buffer

module tb_reorder_buffer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         flush;
    logic         alloc;
    logic [4:0]   alloc_rd;
    logic         rob_full;
    logic [2:0]   rd_rob_tag;
    logic [7:0]   cdb_enable;
    logic [255:0] cdb_data;
    logic [7:0]   robs_calculated;
    logic [2:0]   src1_tag, src2_tag;
    logic [31:0]  src1_rob_data, src2_rob_data;
    logic         regfile_load;
    logic [4:0]   regfile_rd;
    logic [31:0]  regfile_data;
    logic [2:0]   regfile_tag;

    reorder_buffer #(.DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .alloc(alloc), .alloc_rd(alloc_rd),
        .rob_full(rob_full), .rd_rob_tag(rd_rob_tag),
        .cdb_enable(cdb_enable), .cdb_data(cdb_data),
        .robs_calculated(robs_calculated),
        .src1_tag(src1_tag), .src2_tag(src2_tag),
        .src1_rob_data(src1_rob_data), .src2_rob_data(src2_rob_data),
        .regfile_load(regfile_load), .regfile_rd(regfile_rd),
        .regfile_data(regfile_data), .regfile_tag(regfile_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  tag;
        logic [4:0]  rd;
        logic [31:0] val;
        bit          ready;
    } ent_t;

    ent_t        mq[$];      // in-flight instructions in program order
    ent_t        exp_q[$];   // expected retirements, pushed at allocation
    logic [31:0] mdata [8];  // last result written per tag
    logic [2:0]  mtail;
    int          nvec = 0;
    int          nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear(input bit clear_data);
        mq.delete();
        exp_q.delete();
        mtail = 3'd0;
        if (clear_data)
            for (int i = 0; i < 8; i++) mdata[i] = 32'd0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rob_full"}, rob_full, 0);
        chk({tag, "_rd_rob_tag"}, rd_rob_tag, 0);
        chk({tag, "_robs_calc"}, robs_calculated, 0);
        chk({tag, "_regfile_load"}, regfile_load, 0);
        chk({tag, "_regfile_rd"}, regfile_rd, 0);
        chk({tag, "_regfile_data"}, regfile_data, 0);
        chk({tag, "_regfile_tag"}, regfile_tag, 0);
        chk({tag, "_src1_data"}, src1_rob_data, 0);
        chk({tag, "_src2_data"}, src2_rob_data, 0);
    endtask

    // One clock cycle: check registered outputs against the model, drive inputs,
    // check the combinational operand reads, then advance the model at the edge.
    task automatic cycle(input bit a, input logic [4:0] rd, input logic [31:0] v,
                         input logic [7:0] ce, input bit fl);
        logic [7:0] calc;
        bit         full_pre, com;
        ent_t       e;
        @(negedge clk);
        calc = '0;
        foreach (mq[k]) if (mq[k].ready) calc[mq[k].tag] = 1'b1;
        chk("rob_full", rob_full, mq.size() == 8);
        chk("rd_rob_tag", rd_rob_tag, mtail);
        chk("robs_calculated", robs_calculated, calc);
        chk("regfile_load", regfile_load,
            mq.size() > 0 && mq[0].ready && mq[0].rd != 5'd0);
        chk("regfile_tag", regfile_tag, (mq.size() > 0) ? mq[0].tag : mtail);
        if (mq.size() > 0) chk("regfile_rd", regfile_rd, mq[0].rd);

        alloc      = a;
        alloc_rd   = rd;
        cdb_enable = ce;
        flush      = fl;
        for (int i = 0; i < 8; i++) cdb_data[32*i +: 32] = $urandom;
        foreach (mq[k]) cdb_data[32*mq[k].tag +: 32] = mq[k].val;
        src1_tag = 3'($urandom);
        src2_tag = 3'($urandom);
        #1;
        chk("src1_rob_data", src1_rob_data, mdata[src1_tag]);
        chk("src2_rob_data", src2_rob_data, mdata[src2_tag]);

        @(posedge clk);
        if (fl) begin
            model_clear(1'b0);
        end else begin
            full_pre = (mq.size() == 8);
            com      = (mq.size() > 0) && mq[0].ready;
            foreach (mq[k]) begin
                if (ce[mq[k].tag]) begin
                    mq[k].ready      = 1'b1;
                    mdata[mq[k].tag] = mq[k].val;
                end
            end
            if (com) void'(mq.pop_front());
            if (a && !full_pre) begin
                e.tag = mtail; e.rd = rd; e.val = v; e.ready = 1'b0;
                mq.push_back(e);
                exp_q.push_back(e);
                mtail = mtail + 3'd1;
            end
        end
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 8'd0, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && mq.size() > 0; k++)
            cycle(1'b0, 5'd0, 32'd0, 8'hFF, 1'b0);
        chk("drain_empty", mq.size(), 0);
        idle();
    endtask

    task automatic reset_mid();
        @(negedge clk);
        alloc = 1'b0; cdb_enable = 8'd0; flush = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk_zero("async_reset");
        model_clear(1'b1);
        @(negedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Monitor: whenever the head retires, pop the scoreboard and compare.
    always @(negedge clk) begin
        ent_t e;
        if (reset_n === 1'b1 && robs_calculated[regfile_tag] === 1'b1) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_commit actual tag=%0d required none", regfile_tag);
            end else begin
                e = exp_q.pop_front();
                chk("commit_tag", regfile_tag, e.tag);
                chk("commit_rd", regfile_rd, e.rd);
                chk("commit_data", regfile_data, e.val);
                chk("commit_load", regfile_load, e.rd != 5'd0);
            end
        end
    end

    initial begin
        reset_n = 1'b0; flush = 1'b0; alloc = 1'b0; alloc_rd = '0;
        cdb_enable = '0; cdb_data = '0; src1_tag = '0; src2_tag = '0;
        model_clear(1'b1);
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Fill to eight entries, then a ninth alloc is refused.
        for (int i = 0; i < 8; i++) cycle(1'b1, 5'(i + 1), $urandom, 8'd0, 1'b0);
        cycle(1'b1, 5'd9, 32'h9999_9999, 8'd0, 1'b0);
        idle();
        drain();

        // Out-of-order completion, in-order retire.
        cycle(1'b1, 5'd1, 32'h11, 8'd0, 1'b0);
        cycle(1'b1, 5'd2, 32'h22, 8'd0, 1'b0);
        cycle(1'b1, 5'd3, 32'h33, 8'd0, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 8'd1 << mq[2].tag, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 8'd1 << mq[0].tag, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 8'd1 << mq[1].tag, 1'b0);
        drain();

        // Alloc + commit at count 7, then alloc refused at count 8 with commit.
        for (int i = 0; i < 7; i++) cycle(1'b1, 5'(i + 4), $urandom, 8'd0, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 8'd1 << mq[0].tag, 1'b0);
        cycle(1'b1, 5'd20, 32'hA5A5_0001, 8'd0, 1'b0);
        cycle(1'b1, 5'd21, 32'hA5A5_0002, 8'd0, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 8'd1 << mq[0].tag, 1'b0);
        cycle(1'b1, 5'd22, 32'hA5A5_0003, 8'd0, 1'b0);
        idle();
        drain();

        // x0 destination retires without a register file write.
        cycle(1'b1, 5'd0, 32'hDEAD_BEEF, 8'd0, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 8'd1 << mq[0].tag, 1'b0);
        idle();
        idle();

        // Flush with five busy, two ready, and a CDB write present.
        for (int i = 0; i < 5; i++) cycle(1'b1, 5'(i + 10), $urandom, 8'd0, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, (8'd1 << mq[1].tag) | (8'd1 << mq[3].tag), 1'b0);
        cycle(1'b1, 5'd30, $urandom, 8'hFF, 1'b1);
        idle();

        // Same again but with an asynchronous reset pulse.
        for (int i = 0; i < 5; i++) cycle(1'b1, 5'(i + 10), $urandom, 8'd0, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, (8'd1 << mq[0].tag) | (8'd1 << mq[2].tag), 1'b0);
        reset_mid();
        idle();

        // Randomized traffic.
        for (int n = 0; n < 400; n++)
            cycle(($urandom % 3) != 0, 5'($urandom), $urandom,
                  8'($urandom) & 8'($urandom), ($urandom % 50) == 0);
        drain();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
